// File: rtl/mux_nin_reg.sv
// N-input W-bit selector with a registered one-entry valid/ready output.
// Direct-select or round-robin grant among valid producers.
module mux_nin_reg #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 4,
  localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       select,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_src,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_sel
);

  logic              load_en;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_nxt;
  logic [DATA_W-1:0] gnt_data;
  logic              sel_ok;
  logic              xfer;
  logic              illegal;
  int                rr_j;

  assign load_en = !out_valid || out_ready;
  assign sel_ok  = int'(select) < N_IN;
  assign illegal = !mode && !sel_ok && (|in_valid);
  assign xfer    = load_en && gnt_vld && !reset;

  // Grant: direct index in mode 0, first valid from ptr upward in mode 1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_j    = 0;
    if (!mode) begin
      gnt_idx = select;
      for (int i = 0; i < N_IN; i++) begin
        if (select == SEL_W'(i) && in_valid[i]) gnt_vld = 1'b1;
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        rr_j = int'(ptr) + k;
        if (rr_j >= N_IN) rr_j = rr_j - N_IN;
        if (!gnt_vld && in_valid[rr_j]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(rr_j);
        end
      end
    end
  end

  // Word mux and one-hot ready toward the granted producer.
  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data    = in_data[i*DATA_W +: DATA_W];
        in_ready[i] = xfer;
      end
    end
  end

  assign ptr_nxt = (gnt_idx == SEL_W'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;

  // Output buffer, round-robin pointer and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_sel   <= 1'b0;
      ptr       <= '0;
    end else begin
      err_sel <= illegal;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_src   <= gnt_idx;
        if (mode) ptr <= ptr_nxt;
      end else if (load_en) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nin_reg.sv
// Bench for mux_nin_reg: 4-input and 3-input instances on shared stimulus,
// checked every cycle against a behavioural model plus literal expectations.
module tb_mux_nin_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic [1:0]   select;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic         out_ready;

  logic [3:0]   rdy_a;
  logic [31:0]  dat_a;
  logic [1:0]   src_a;
  logic         vld_a;
  logic         err_a;
  logic [2:0]   rdy_b;
  logic [31:0]  dat_b;
  logic [1:0]   src_b;
  logic         vld_b;
  logic         err_b;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mux_nin_reg #(.DATA_W(32), .N_IN(4)) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .out_data(dat_a), .out_src(src_a), .out_valid(vld_a),
    .out_ready(out_ready), .err_sel(err_a)
  );

  mux_nin_reg #(.DATA_W(32), .N_IN(3)) dut_b (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data[95:0]), .in_valid(in_valid[2:0]), .in_ready(rdy_b),
    .out_data(dat_b), .out_src(src_b), .out_valid(vld_b),
    .out_ready(out_ready), .err_sel(err_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state per instance: 0 -> four inputs, 1 -> three inputs.
  bit          mv[2];
  logic [31:0] md[2];
  int          ms[2];
  bit          me[2];
  int          mp[2];

  function automatic int n_of(int u);
    return (u == 0) ? 4 : 3;
  endfunction

  function automatic void grant(int n, int p, output bit g, output int idx);
    g   = 1'b0;
    idx = 0;
    if (!mode) begin
      idx = int'(select);
      g   = (idx < n) && in_valid[idx];
    end else begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (p + k) % n;
        if (!g && in_valid[j]) begin
          g   = 1'b1;
          idx = j;
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_rdy(int u);
    bit g;
    int idx;
    logic [3:0] r;
    r = 4'b0;
    grant(n_of(u), mp[u], g, idx);
    if (!reset && g && (!mv[u] || out_ready)) r[idx] = 1'b1;
    return r;
  endfunction

  // Model advances on the same edge as the designs.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit g;
      int idx;
      int n;
      n = n_of(u);
      if (reset) begin
        mv[u] = 0; md[u] = 0; ms[u] = 0; me[u] = 0; mp[u] = 0;
      end else begin
        grant(n, mp[u], g, idx);
        me[u] = !mode && int'(select) >= n &&
                ((in_valid & 4'((1 << n) - 1)) != 0);
        if (!mv[u] || out_ready) begin
          if (g) begin
            mv[u] = 1;
            md[u] = in_data[idx*32 +: 32];
            ms[u] = idx;
            if (mode) mp[u] = (idx + 1) % n;
          end else begin
            mv[u] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_in_ready", 32'(rdy_a), 32'(exp_rdy(0)));
      chk("a_out_valid", 32'(vld_a), 32'(mv[0]));
      chk("a_out_data", dat_a, md[0]);
      chk("a_out_src", 32'(src_a), 32'(ms[0]));
      chk("a_err_sel", 32'(err_a), 32'(me[0]));
      chk("b_in_ready", 32'(rdy_b), 32'(exp_rdy(1) & 4'b0111));
      chk("b_out_valid", 32'(vld_b), 32'(mv[1]));
      chk("b_out_data", dat_b, md[1]);
      chk("b_out_src", 32'(src_b), 32'(ms[1]));
      chk("b_err_sel", 32'(err_b), 32'(me[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; mode = 1'b0; select = 2'd0;
    in_data = '0; in_valid = 4'b0; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("idle_valid", 32'(vld_a), 32'd0);
    chk("idle_data", dat_a, 32'd0);
    chk("idle_rdy", 32'(rdy_a), 32'd0);
    chk("idle_err", 32'(err_b), 32'd0);

    // Direct select streaming.
    select = 2'd2; in_data[64 +: 32] = 32'hDEADBEEF;
    in_valid = 4'b0100; out_ready = 1'b1;
    #1 chk("m0_rdy", 32'(rdy_a), 32'h4);
    tick();
    chk("m0_valid", 32'(vld_a), 32'd1);
    chk("m0_data", dat_a, 32'hDEADBEEF);
    chk("m0_src", 32'(src_a), 32'd2);
    select = 2'd1;
    tick();
    chk("m0_drop", 32'(vld_a), 32'd0);

    // Back-pressure, then drain and reload on one edge.
    select = 2'd0; in_data[31:0] = 32'h11111111; in_valid = 4'b0001;
    tick();
    in_valid = 4'b0011; out_ready = 1'b0; in_data[31:0] = 32'h22222222;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_rdy", 32'(rdy_a), 32'd0);
      tick();
      chk("bp_data", dat_a, 32'h11111111);
      chk("bp_src", 32'(src_a), 32'd0);
      chk("bp_valid", 32'(vld_a), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_nobubble_v", 32'(vld_a), 32'd1);
    chk("bp_nobubble_d", dat_a, 32'h22222222);

    // Round-robin fairness.
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + i;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rr_src", 32'(src_a), 32'(rr_exp[c]));
    end
    in_valid = 4'b1001;
    tick();
    chk("rr_skip3", 32'(src_a), 32'd3);
    tick();
    chk("rr_wrap0", 32'(src_a), 32'd0);

    // Illegal select on the three-input instance.
    mode = 1'b0; select = 2'd3; in_valid = 4'b0111;
    #1 chk("ill_rdy", 32'(rdy_b), 32'd0);
    tick();
    chk("ill_err1", 32'(err_b), 32'd1);
    chk("ill_vld", 32'(vld_b), 32'd0);
    tick();
    chk("ill_err2", 32'(err_b), 32'd1);
    in_valid = 4'b0000;
    tick();
    chk("ill_clr", 32'(err_b), 32'd0);

    // Reset while stalled.
    select = 2'd1; in_data[32 +: 32] = 32'hCAFEF00D; in_valid = 4'b0010;
    tick();
    chk("rs_load", dat_a, 32'hCAFEF00D);
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rs_valid", 32'(vld_a), 32'd0);
    chk("rs_data", dat_a, 32'd0);
    #1 chk("rs_rdy", 32'(rdy_a), 32'd0);
    reset = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    chk("rs_ptr0", 32'(src_a), 32'd0);
    tick();
    chk("rs_ptr1", 32'(src_a), 32'd1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
